// File: rtl/mem_bus_arbiter.sv
// Arbitrates the instruction and data caches onto one memory port.
// Tracks in-flight loads by memory tag so that returned data reaches its owner.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  icache_command,
  input  logic [63:0] icache_addr,
  input  logic [1:0]  dcache_command,
  input  logic [63:0] dcache_addr,
  input  logic [63:0] dcache_data,
  input  logic [1:0]  dcache_size,
  input  logic [3:0]  Imem2proc_response,
  input  logic [63:0] Imem2proc_data,
  input  logic [3:0]  Imem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [1:0]  proc2mem_size,
  output logic [3:0]  icache_response,
  output logic [3:0]  dcache_response,
  output logic        icache_data_valid,
  output logic        dcache_data_valid,
  output logic [63:0] mem_data,
  output logic [3:0]  mem_tag,
  output logic [3:0]  outstanding_count
);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] DOUBLE    = 2'd3;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic vld;
    logic dside;
  } own_t;

  own_t [15:0]   owner_table;
  logic [SW-1:0] starve_cnt;
  logic          load_ok, i_want, d_want, i_prio, grant_i, grant_d;
  logic          load_acc, ret_hit;

  always_comb begin
    outstanding_count = '0;
    for (int i = 1; i < 16; i++)
      outstanding_count = outstanding_count + {3'b0, owner_table[i].vld};
  end

  // Loads stall when the tag table is full; stores never occupy an entry.
  assign load_ok = outstanding_count < 4'(MAX_OUTSTANDING);
  assign i_want  = !reset && icache_command == BUS_LOAD && load_ok;
  assign d_want  = !reset && (dcache_command == BUS_STORE ||
                              (dcache_command == BUS_LOAD && load_ok));
  assign i_prio  = starve_cnt == SW'(STARVE_LIMIT);
  assign grant_i = i_want && (i_prio || !d_want);
  assign grant_d = d_want && !grant_i;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    if (grant_i) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = {icache_addr[63:3], 3'b000};
      proc2mem_size    = DOUBLE;
    end else if (grant_d) begin
      proc2mem_command = dcache_command;
      proc2mem_addr    = {dcache_addr[63:3], 3'b000};
      proc2mem_data    = dcache_data;
      proc2mem_size    = dcache_size;
    end
  end

  assign icache_response   = grant_i ? Imem2proc_response : 4'd0;
  assign dcache_response   = grant_d ? Imem2proc_response : 4'd0;
  assign load_acc          = (grant_i || (grant_d && dcache_command == BUS_LOAD)) &&
                             Imem2proc_response != 4'd0;
  assign ret_hit           = !reset && Imem2proc_tag != 4'd0 && owner_table[Imem2proc_tag].vld;
  assign icache_data_valid = ret_hit && !owner_table[Imem2proc_tag].dside;
  assign dcache_data_valid = ret_hit &&  owner_table[Imem2proc_tag].dside;
  assign mem_data          = Imem2proc_data;
  assign mem_tag           = Imem2proc_tag;

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_table <= '0;
      starve_cnt  <= '0;
    end else begin
      // Set after clear so a same-cycle reuse of a returning tag sticks.
      if (ret_hit) owner_table[Imem2proc_tag].vld <= 1'b0;
      if (load_acc) owner_table[Imem2proc_response] <= '{vld: 1'b1, dside: grant_d};
      if (icache_command == BUS_LOAD && !grant_i)
        starve_cnt <= i_prio ? starve_cnt : starve_cnt + SW'(1);
      else
        starve_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus random checks of mem_bus_arbiter against a tag-ownership model.
module tb_mem_bus_arbiter;
  localparam int LIMIT = 4;
  localparam int MAXO  = 8;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

  logic        clock = 1'b0, reset = 1'b1;
  logic [1:0]  icache_command = '0, dcache_command = '0, dcache_size = '0;
  logic [63:0] icache_addr = '0, dcache_addr = '0, dcache_data = '0, Imem2proc_data = '0;
  logic [3:0]  Imem2proc_response = '0, Imem2proc_tag = '0;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [63:0] proc2mem_addr, proc2mem_data, mem_data;
  logic [3:0]  icache_response, dcache_response, mem_tag, outstanding_count;
  logic        icache_data_valid, dcache_data_valid;

  int total = 0, bad = 0;
  int m_owner[16];  // -1 free, 0 instruction side, 1 data side
  int m_starve = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .icache_command(icache_command), .icache_addr(icache_addr),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr),
    .dcache_data(dcache_data), .dcache_size(dcache_size),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
    .Imem2proc_tag(Imem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .icache_response(icache_response), .dcache_response(dcache_response),
    .icache_data_valid(icache_data_valid), .dcache_data_valid(dcache_data_valid),
    .mem_data(mem_data), .mem_tag(mem_tag), .outstanding_count(outstanding_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    foreach (m_owner[i]) if (m_owner[i] >= 0) n++;
    return n;
  endfunction

  task automatic drive(input logic [1:0] ic, input logic [1:0] dc,
                       input logic [3:0] resp, input logic [3:0] tag);
    icache_command     = ic;
    dcache_command     = dc;
    Imem2proc_response = resp;
    Imem2proc_tag      = tag;
    icache_addr        = {$urandom, $urandom};
    dcache_addr        = {$urandom, $urandom};
    dcache_data        = {$urandom, $urandom};
    Imem2proc_data     = {$urandom, $urandom};
    dcache_size        = 2'($urandom_range(0, 3));
    #1;
  endtask

  // Check all outputs against the model, then advance one clock and update it.
  task automatic cyc();
    int  cnt = m_count();
    bit  lok = cnt < MAXO;
    bit  iw  = !reset && icache_command == LOAD && lok;
    bit  dw  = !reset && (dcache_command == STORE || (dcache_command == LOAD && lok));
    int  win = -1;  // 0 instruction, 1 data
    bit  hit = !reset && Imem2proc_tag != 0 && m_owner[Imem2proc_tag] >= 0;
    if (iw && (m_starve == LIMIT || !dw)) win = 0;
    else if (dw) win = 1;
    chk("count", outstanding_count, cnt);
    chk("cmd", proc2mem_command, win == 0 ? LOAD : win == 1 ? dcache_command : NONE);
    if (win == 0) begin
      chk("iaddr", proc2mem_addr, icache_addr & ~64'h7);
      chk("isize", proc2mem_size, 2'd3);
      chk("idata", proc2mem_data, 64'd0);
    end else if (win == 1) begin
      chk("daddr", proc2mem_addr, dcache_addr & ~64'h7);
      chk("dsize", proc2mem_size, dcache_size);
      chk("ddata", proc2mem_data, dcache_data);
    end
    chk("iresp", icache_response, win == 0 ? Imem2proc_response : 4'd0);
    chk("dresp", dcache_response, win == 1 ? Imem2proc_response : 4'd0);
    chk("idv", icache_data_valid, hit && m_owner[Imem2proc_tag] == 0);
    chk("ddv", dcache_data_valid, hit && m_owner[Imem2proc_tag] == 1);
    chk("mdata", mem_data, Imem2proc_data);
    chk("mtag", mem_tag, Imem2proc_tag);
    @(posedge clock);
    if (reset) begin
      foreach (m_owner[i]) m_owner[i] = -1;
      m_starve = 0;
    end else begin
      if (hit) m_owner[Imem2proc_tag] = -1;
      if (win >= 0 && Imem2proc_response != 0 &&
          (win == 0 || dcache_command == LOAD))
        m_owner[Imem2proc_response] = win;
      if (icache_command == LOAD && win != 0)
        m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else
        m_starve = 0;
    end
    #1;
  endtask

  task automatic drain();
    for (int t = 1; t < 16; t++) begin
      drive(NONE, NONE, 0, 4'(t));
      cyc();
    end
  endtask

  initial begin
    foreach (m_owner[i]) m_owner[i] = -1;
    @(posedge clock); #1;
    // Reset holds everything quiet even with requests and returns present.
    drive(LOAD, LOAD, 3, 3); cyc();
    chk("rst_cmd", proc2mem_command, NONE);
    drive(LOAD, STORE, 4, 4); cyc();
    reset = 1'b0;

    // Contention: data side wins, tag 3 then returns to the data side.
    drive(LOAD, LOAD, 3, 0);
    chk("c_dresp", dcache_response, 4'd3);
    chk("c_iresp", icache_response, 4'd0);
    cyc();
    drive(NONE, NONE, 0, 3);
    chk("c_ret", dcache_data_valid, 1'b1);
    cyc();

    // Starvation: instruction side wins on the fifth contended cycle.
    for (int k = 1; k <= 4; k++) begin
      drive(LOAD, LOAD, 4'(k), 0);
      chk("s_lose", icache_response, 4'd0);
      cyc();
    end
    drive(LOAD, LOAD, 6, 0);
    chk("s_win", icache_response, 4'd6);
    cyc();
    drive(LOAD, LOAD, 0, 0); cyc();
    drive(NONE, NONE, 0, 0); cyc();
    drain();

    // Stores take no tag-table entry.
    drive(NONE, STORE, 5, 0);
    chk("st_resp", dcache_response, 4'd5);
    cyc();
    chk("st_cnt", outstanding_count, 4'd0);
    drive(NONE, NONE, 0, 5);
    chk("st_ret", dcache_data_valid, 1'b0);
    cyc();

    // Table full: loads stall, stores pass, a return frees a slot.
    for (int k = 1; k <= 8; k++) begin drive(LOAD, LOAD, 4'(k), 0); cyc(); end
    chk("f_cnt", outstanding_count, 4'd8);
    drive(LOAD, LOAD, 9, 0);
    chk("f_blk", proc2mem_command, NONE);
    cyc();
    drive(LOAD, STORE, 9, 0);
    chk("f_st", proc2mem_command, STORE);
    cyc();
    drive(NONE, NONE, 0, 1); cyc();
    drive(NONE, LOAD, 10, 0);
    chk("f_res", dcache_response, 4'd10);
    cyc();
    drain();

    // Same-cycle return and reuse of tag 7.
    drive(LOAD, NONE, 7, 0); cyc();
    drive(NONE, LOAD, 7, 7);
    chk("r_idv", icache_data_valid, 1'b1);
    cyc();
    drive(NONE, NONE, 0, 7);
    chk("r_ddv", dcache_data_valid, 1'b1);
    cyc();

    // Reset mid-flight discards ownership.
    for (int k = 1; k <= 3; k++) begin drive(NONE, LOAD, 4'(k), 0); cyc(); end
    reset = 1'b1; drive(NONE, NONE, 0, 0); cyc();
    reset = 1'b0;
    chk("x_cnt", outstanding_count, 4'd0);
    drive(NONE, NONE, 0, 2);
    chk("x_idv", icache_data_valid, 1'b0);
    chk("x_ddv", dcache_data_valid, 1'b0);
    cyc();

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive(2'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
            $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0,
            $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
